// File: rtl/vga_timing_pipe_if.sv
// vga_timing_pipe_if
//   Bundles the pixel-memory request/response signals and the VGA pin
//   signals of vga_timing_pipe.
//   Parameter ADDR_W : width of h_addr / v_addr.
//   Signals:
//     h_addr, v_addr : pixel column / row requested from the frame memory
//     rd_en          : current address lies in the visible region
//     vga_data       : {R,G,B} returned by the frame memory
//     hsync, vsync   : sync pins, polarity set by the timing generator
//     valid          : blank_n, high on displayed pixels
//     vga_r/g/b      : colour pins
//   Modports:
//     master : the timing generator (drives addresses and pins, reads vga_data)
//     slave  : memory / display side (drives vga_data, observes the rest)
interface vga_timing_pipe_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] h_addr;
  logic [ADDR_W-1:0] v_addr;
  logic              rd_en;
  logic [23:0]       vga_data;
  logic              hsync;
  logic              vsync;
  logic              valid;
  logic [7:0]        vga_r;
  logic [7:0]        vga_g;
  logic [7:0]        vga_b;

  modport master (
    output h_addr, v_addr, rd_en,
    output hsync, vsync, valid, vga_r, vga_g, vga_b,
    input  vga_data
  );

  modport slave (
    input  h_addr, v_addr, rd_en,
    input  hsync, vsync, valid, vga_r, vga_g, vga_b,
    output vga_data
  );
endinterface

// File: rtl/vga_timing_pipe.sv
// vga_timing_pipe
//   Programmable VGA timing generator. Requests pixels from a frame memory
//   by (h_addr, v_addr), absorbs the memory read latency MEM_LAT (0..4) with
//   an internal delay line and drives registered, aligned sync/blank/RGB.
//   Pins lag the counters by MEM_LAT+1 cycles; line/frame strobes and the
//   frame counter are registered straight from counter state.
//   Ports:
//     clk         : pixel clock
//     resetn      : asynchronous reset, active-low
//     en          : timing advance enable, low freezes everything
//     pattern_sel : (VGA_TEST_PATTERN_EN only) select built-in colour bars
//     bus         : vga_timing_pipe_if.master (addresses, rd_en, vga_data, pins)
//     line_start  : one-cycle pulse when a line starts
//     frame_start : one-cycle pulse when a frame starts
//     frame_cnt   : frames started since reset, wraps 255 -> 0
//   Optional feature macro: VGA_TEST_PATTERN_EN adds pattern_sel and an
//   8-bar colour pattern replacing vga_data on displayed pixels.
module vga_timing_pipe #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int MEM_LAT  = 1,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              pattern_sel,
`endif
  vga_timing_pipe_if.master bus,
  output logic              line_start,
  output logic              frame_start,
  output logic [7:0]        frame_cnt
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int MAX_TOT  = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
  localparam int CNT_W    = $clog2(MAX_TOT + 1);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam logic SYNC_ACT = (SYNC_POL != 0) ? 1'b1 : 1'b0;

`ifdef VGA_TEST_PATTERN_EN
  // Delay-line word also carries the column so the bar index stays aligned.
  localparam int TAP_W = 3 + CNT_W;
  localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
`else
  localparam int TAP_W = 3;
`endif

  logic [CNT_W-1:0] h_cnt_r;
  logic [CNT_W-1:0] v_cnt_r;
  logic             h_last_s;
  logic             v_last_s;
  logic             frame_top_s;
  logic             rd_en_s;
  logic             hs_raw_s;
  logic             vs_raw_s;
  logic [TAP_W-1:0] head_s;
  logic [TAP_W-1:0] tail_s;
  logic             tail_rd_s;
  logic             tail_hs_s;
  logic             tail_vs_s;
  logic [23:0]      pix_s;
  logic             valid_r;
  logic             hsync_r;
  logic             vsync_r;
  logic [23:0]      rgb_r;
  logic             line_start_r;
  logic             frame_start_r;
  logic [7:0]       frame_cnt_r;

  // Map a raw (active-high) sync flag to the pin level.
  function automatic logic sync_level(input logic raw);
    return raw ? SYNC_ACT : ~SYNC_ACT;
  endfunction

`ifdef VGA_TEST_PATTERN_EN
  // Colour for column col: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [23:0] color_bar(input logic [CNT_W-1:0] col);
    logic [CNT_W-1:0] idx;
    idx = col / CNT_W'(BAR_W);
    case (idx)
      CNT_W'(0): return 24'hFFFFFF;
      CNT_W'(1): return 24'hFFFF00;
      CNT_W'(2): return 24'h00FFFF;
      CNT_W'(3): return 24'h00FF00;
      CNT_W'(4): return 24'hFF00FF;
      CNT_W'(5): return 24'hFF0000;
      CNT_W'(6): return 24'h0000FF;
      default:   return 24'h000000;
    endcase
  endfunction
`endif

  assign h_last_s    = (h_cnt_r == CNT_W'(H_TOTAL - 1));
  assign v_last_s    = (v_cnt_r == CNT_W'(V_TOTAL - 1));
  assign frame_top_s = (h_cnt_r == {CNT_W{1'b0}}) && (v_cnt_r == {CNT_W{1'b0}});
  assign rd_en_s     = (h_cnt_r < CNT_W'(H_ACTIVE)) && (v_cnt_r < CNT_W'(V_ACTIVE));
  assign hs_raw_s    = (h_cnt_r >= CNT_W'(HS_START)) && (h_cnt_r < CNT_W'(HS_END));
  assign vs_raw_s    = (v_cnt_r >= CNT_W'(VS_START)) && (v_cnt_r < CNT_W'(VS_END));

  assign bus.h_addr  = ADDR_W'(h_cnt_r);
  assign bus.v_addr  = ADDR_W'(v_cnt_r);
  assign bus.rd_en   = rd_en_s;

`ifdef VGA_TEST_PATTERN_EN
  assign head_s = {rd_en_s, hs_raw_s, vs_raw_s, h_cnt_r};
`else
  assign head_s = {rd_en_s, hs_raw_s, vs_raw_s};
`endif

  // Horizontal / vertical position counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_cnt_r <= {CNT_W{1'b0}};
      v_cnt_r <= {CNT_W{1'b0}};
    end else if (en) begin
      if (h_last_s) begin
        h_cnt_r <= {CNT_W{1'b0}};
        if (v_last_s) begin
          v_cnt_r <= {CNT_W{1'b0}};
        end else begin
          v_cnt_r <= v_cnt_r + CNT_W'(1);
        end
      end else begin
        h_cnt_r <= h_cnt_r + CNT_W'(1);
      end
    end
  end

  // Delay line matching the memory read latency; absent when MEM_LAT is 0.
  generate
    if (MEM_LAT == 0) begin : g_no_delay
      assign tail_s = head_s;
    end else begin : g_delay
      logic [TAP_W-1:0] pipe_r [MEM_LAT];

      // Shift the control word one stage per enabled clock.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          for (int i = 0; i < MEM_LAT; i++) begin
            pipe_r[i] <= {TAP_W{1'b0}};
          end
        end else if (en) begin
          pipe_r[0] <= head_s;
          for (int i = 1; i < MEM_LAT; i++) begin
            pipe_r[i] <= pipe_r[i-1];
          end
        end
      end

      assign tail_s = pipe_r[MEM_LAT-1];
    end
  endgenerate

  assign tail_rd_s = tail_s[TAP_W-1];
  assign tail_hs_s = tail_s[TAP_W-2];
  assign tail_vs_s = tail_s[TAP_W-3];

  // Select the pixel for the output stage; black outside the visible region.
  always_comb begin
    pix_s = 24'h000000;
    if (tail_rd_s) begin
`ifdef VGA_TEST_PATTERN_EN
      if (pattern_sel) begin
        pix_s = color_bar(tail_s[CNT_W-1:0]);
      end else begin
        pix_s = bus.vga_data;
      end
`else
      pix_s = bus.vga_data;
`endif
    end else begin
      pix_s = 24'h000000;
    end
  end

  // Output register stage for sync, blank and colour pins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_r <= 1'b0;
      hsync_r <= ~SYNC_ACT;
      vsync_r <= ~SYNC_ACT;
      rgb_r   <= 24'h000000;
    end else if (en) begin
      valid_r <= tail_rd_s;
      hsync_r <= sync_level(tail_hs_s);
      vsync_r <= sync_level(tail_vs_s);
      rgb_r   <= pix_s;
    end
  end

  // Line/frame strobes and frame counter, taken from undelayed counter state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_cnt_r   <= 8'd0;
    end else if (en) begin
      line_start_r  <= (h_cnt_r == {CNT_W{1'b0}});
      frame_start_r <= frame_top_s;
      if (frame_top_s) begin
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end
    end else begin
      // Strobes never stretch across a stall.
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end
  end

  assign bus.valid   = valid_r;
  assign bus.hsync   = hsync_r;
  assign bus.vsync   = vsync_r;
  assign bus.vga_r   = rgb_r[23:16];
  assign bus.vga_g   = rgb_r[15:8];
  assign bus.vga_b   = rgb_r[7:0];
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;
  assign frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// tb_vga_timing_pipe
//   Two instances: dut_a with default 640x480 timing (MEM_LAT=1, active-low
//   sync) and dut_b with a tiny 7x5 timing (MEM_LAT=2, active-high sync,
//   ADDR_W=8). Frame memories are modelled as en-gated register chains
//   returning {pad, v_addr, h_addr}.
module tb_vga_timing_pipe;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic en_a = 1'b0;
  logic en_b = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  vga_timing_pipe_if #(.ADDR_W(10)) bus_a ();
  vga_timing_pipe_if #(.ADDR_W(8))  bus_b ();

  logic       ls_a, fs_a, ls_b, fs_b;
  logic [7:0] fc_a, fc_b;

  logic [23:0] mem_a = 24'h0;
  logic [23:0] mem_b1 = 24'h0;
  logic [23:0] mem_b2 = 24'h0;

  always #5 clk = ~clk;

  vga_timing_pipe #(.MEM_LAT(1), .SYNC_POL(0), .ADDR_W(10)) dut_a (
    .clk(clk), .resetn(resetn), .en(en_a),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(1'b0),
`endif
    .bus(bus_a), .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
  );

  vga_timing_pipe #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1), .MEM_LAT(2), .ADDR_W(8)
  ) dut_b (
    .clk(clk), .resetn(resetn), .en(en_b),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(1'b0),
`endif
    .bus(bus_b), .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
  );

  // Frame memory models: latency 1 for dut_a, latency 2 for dut_b.
  always @(posedge clk) begin
    if (en_a) mem_a <= {4'h0, bus_a.v_addr, bus_a.h_addr};
    if (en_b) begin
      mem_b1 <= {8'h00, bus_b.v_addr, bus_b.h_addr};
      mem_b2 <= mem_b1;
    end
  end
  assign bus_a.vga_data = mem_a;
  assign bus_b.vga_data = mem_b2;

  // Expected dut_b pins per frame position t = 7*v + h: {valid, hsync, vsync}.
  logic [2:0] exp_flag [35] = '{
    3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b010, 3'b000,
    3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b010, 3'b000,
    3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000,
    3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b011, 3'b001,
    3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000
  };
  logic [23:0] exp_rgb [35] = '{
    24'h000000, 24'h000001, 24'h000002, 24'h000003, 24'h0, 24'h0, 24'h0,
    24'h000100, 24'h000101, 24'h000102, 24'h000103, 24'h0, 24'h0, 24'h0,
    24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0,
    24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0,
    24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0
  };

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] rgb_a();
    return {bus_a.vga_r, bus_a.vga_g, bus_a.vga_b};
  endfunction

  function automatic logic [23:0] rgb_b();
    return {bus_b.vga_r, bus_b.vga_g, bus_b.vga_b};
  endfunction

  initial begin
    int t_ls2, t_vrise, t_vfall, t_hfall, t_hrise;
    logic pv, ph, moved, strobe_seen;
    int t, fs_count, prev_fc;
    logic [2:0] fl;

    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("rst_hsync_a", bus_a.hsync, 1);
    check_eq("rst_vsync_a", bus_a.vsync, 1);
    check_eq("rst_valid_a", bus_a.valid, 0);
    check_eq("rst_rgb_a", rgb_a(), 0);
    check_eq("rst_strobes_a", {ls_a, fs_a}, 0);
    check_eq("rst_fcnt_a", fc_a, 0);
    check_eq("rst_haddr_a", bus_a.h_addr, 0);
    check_eq("rst_rden_a", bus_a.rd_en, 1);
    check_eq("rst_syncs_b", {bus_b.hsync, bus_b.vsync}, 0);

    // First enabled edge after release: frame_start and line_start.
    resetn = 1'b1;
    en_a = 1'b1;
    @(negedge clk);
    check_eq("first_fs_a", fs_a, 1);
    check_eq("first_ls_a", ls_a, 1);
    check_eq("first_fcnt_a", fc_a, 1);
    check_eq("first_haddr_a", bus_a.h_addr, 1);
    check_eq("first_valid_a", bus_a.valid, 0);

    // Line timing of dut_a, pins reflect h = c - 2.
    t_ls2 = -1; t_vrise = -1; t_vfall = -1; t_hfall = -1; t_hrise = -1;
    pv = bus_a.valid;
    ph = bus_a.hsync;
    for (int c = 2; c <= 900; c++) begin
      @(negedge clk);
      if (ls_a && t_ls2 < 0) t_ls2 = c;
      if (bus_a.valid && !pv && t_vrise < 0) t_vrise = c;
      if (!bus_a.valid && pv && t_vfall < 0) t_vfall = c;
      if (!bus_a.hsync && ph && t_hfall < 0) t_hfall = c;
      if (bus_a.hsync && !ph && t_hrise < 0) t_hrise = c;
      if (c == 7)   check_eq("pix_h5_a", rgb_a(), 24'h000005);
      if (c == 302) check_eq("pix_h300_a", rgb_a(), 24'h00012C);
      if (c == 700) check_eq("blank_rgb_a", rgb_a(), 24'h000000);
      pv = bus_a.valid;
      ph = bus_a.hsync;
    end
    check_eq("line_period_a", t_ls2 - 1, 800);
    check_eq("valid_rise_a", t_vrise, 2);
    check_eq("valid_width_a", t_vfall - t_vrise, 640);
    check_eq("hsync_offset_a", t_hfall - t_vrise, 656);
    check_eq("hsync_width_a", t_hrise - t_hfall, 96);

    // Stall mid-active-line (line 1, column 100).
    check_eq("pre_hold_h_a", bus_a.h_addr, 100);
    check_eq("pre_hold_v_a", bus_a.v_addr, 1);
    check_eq("pre_hold_rgb_a", rgb_a(), 24'h000462);
    en_a = 1'b0;
    moved = 1'b0;
    strobe_seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (bus_a.h_addr != 10'd100 || rgb_a() != 24'h000462 || bus_a.valid != 1'b1) moved = 1'b1;
      if (ls_a || fs_a) strobe_seen = 1'b1;
    end
    check_eq("hold_frozen_a", moved, 0);
    check_eq("hold_strobe_a", strobe_seen, 0);
    en_a = 1'b1;
    @(negedge clk);
    check_eq("resume_h_a", bus_a.h_addr, 101);
    check_eq("resume_rgb_a", rgb_a(), 24'h000463);

    // Asynchronous reset at column 300.
    repeat (199) @(negedge clk);
    check_eq("pre_rst_h_a", bus_a.h_addr, 300);
    check_eq("pre_rst_valid_a", bus_a.valid, 1);
    resetn = 1'b0;
    #1;
    check_eq("arst_h_a", bus_a.h_addr, 0);
    check_eq("arst_v_a", bus_a.v_addr, 0);
    check_eq("arst_valid_a", bus_a.valid, 0);
    check_eq("arst_rgb_a", rgb_a(), 0);
    check_eq("arst_fcnt_a", fc_a, 0);
    check_eq("arst_syncs_a", {bus_a.hsync, bus_a.vsync}, 2'b11);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check_eq("rel_h_a", bus_a.h_addr, 0);
    @(negedge clk);
    check_eq("rel_fs_a", fs_a, 1);
    check_eq("rel_h1_a", bus_a.h_addr, 1);
    check_eq("rel_fcnt_a", fc_a, 1);
    en_a = 1'b0;

    // dut_b: pins lag counters by 3 cycles; frame is 35 cycles.
    en_b = 1'b1;
    fs_count = 0;
    for (int k = 1; k <= 38; k++) begin
      @(negedge clk);
      t = k - 3;
      fl = (t < 0) ? 3'b000 : exp_flag[t % 35];
      check_eq($sformatf("flags_b_k%0d", k), {bus_b.valid, bus_b.hsync, bus_b.vsync}, fl);
      check_eq($sformatf("rgb_b_k%0d", k), rgb_b(), (t < 0) ? 24'h0 : exp_rgb[t % 35]);
      check_eq($sformatf("ls_b_k%0d", k), ls_b, ((k - 1) % 7) == 0);
      check_eq($sformatf("fs_b_k%0d", k), fs_b, ((k - 1) % 35) == 0);
      if (fs_b) fs_count++;
    end
    check_eq("fcnt_b_2frames", fc_b, 2);

    // Run to the 256th frame_start: counter wraps to 0 with the strobe.
    prev_fc = fc_b;
    for (int k = 0; k < 256 * 35 && fs_count < 256; k++) begin
      @(negedge clk);
      if (fs_b) begin
        fs_count++;
        if (fs_count == 255) check_eq("fcnt_b_255", fc_b, 255);
        if (fs_count == 256) begin
          check_eq("fcnt_b_wrap", fc_b, 0);
          check_eq("fcnt_b_before_wrap", prev_fc, 255);
        end
      end
      prev_fc = fc_b;
    end
    check_eq("frames_seen_b", fs_count, 256);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
